// File: rtl/fetch_unit_pkg.sv
// Shared ISA constants and fetch state encoding for the instruction fetch front end.
package fetch_unit_pkg;

  localparam logic [4:0]  OP_HALT  = 5'b00000;
  localparam logic [4:0]  OP_NOP   = 5'b00001;
  localparam logic [4:0]  OP_SIIC  = 5'b00010;
  localparam logic [4:0]  OP_RTI   = 5'b00011;
  localparam logic [15:0] NOP_WORD = 16'h0800;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_WAIT,
    ST_DRAIN,
    ST_STOP,
    ST_HALTED
  } fetch_state_e;

  function automatic logic [4:0] opcode_of(input logic [15:0] word);
    return word[15:11];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port: one-outstanding request/accept plus a returned data beat.
interface fetch_unit_if #(
  parameter int ADDR_W = 16
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rdy;
  logic              imem_valid;
  logic [15:0]       imem_data;

  modport master (
    output imem_req, imem_addr,
    input  imem_rdy, imem_valid, imem_data
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_rdy, imem_valid, imem_data
  );

endinterface

// File: rtl/fetch_unit_out_reg.sv
// Single-entry instruction buffer between fetch and decode: load, valid/ready pop, flush.
module fetch_out_reg
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [15:0]       load_data,
  input  logic [ADDR_W-1:0] load_pc2,
  input  logic              pop,
  input  logic              flush,
  output logic              valid,
  output logic [15:0]       data,
  output logic [ADDR_W-1:0] pc2
);

  logic              valid_q, valid_d;
  logic [15:0]       data_q, data_d;
  logic [ADDR_W-1:0] pc2_q, pc2_d;

  always_comb begin
    // NOTE: every output takes its held value first, so no path can infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    pc2_d   = pc2_q;
    if (pop) valid_d = 1'b0;
    // A refill in the same cycle as a pop keeps the buffer full.
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
      pc2_d   = load_pc2;
    end
    if (flush) valid_d = 1'b0;
  end

  // NOTE: non-blocking assignments so all state flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= NOP_WORD;
      pc2_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc2_q   <= pc2_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;
  assign pc2   = pc2_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one-outstanding imem reads, buffers one word.
// Optional build macro FETCH_EXC_EN adds an EPC register with SIIC/RTI redirection.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(16'h0002)
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      imem,
  output logic [15:0]       instr,
  output logic [ADDR_W-1:0] instr_pc2,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  input  logic              siic,
  input  logic              rti,
  output logic              halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              halted_q, halted_d;

  logic              buf_valid;
  logic [15:0]       buf_data;
  logic [ADDR_W-1:0] buf_pc2;
  logic              buf_load;
  logic              buf_flush;

  logic              redir_any;
  logic [ADDR_W-1:0] redir_tgt;
  logic              issue;

`ifdef FETCH_EXC_EN
  logic [ADDR_W-1:0] epc_q, epc_d;

  always_comb begin
    redir_any = redirect | siic | rti;
    if (redirect)  redir_tgt = redirect_pc;
    else if (siic) redir_tgt = EXC_VECTOR;
    else           redir_tgt = epc_q;
    epc_d = epc_q;
    // EPC captures the return address of the SIIC word decode is consuming now.
    if (siic && !redirect && !halt && state_q != ST_HALTED) epc_d = buf_pc2;
  end

  always_ff @(posedge clk) begin
    if (rst) epc_q <= '0;
    else     epc_q <= epc_d;
  end
`else
  logic unused_exc;

  always_comb begin
    redir_any = redirect;
    redir_tgt = redirect_pc;
  end

  assign unused_exc = ^{siic, rti, EXC_VECTOR};
`endif

  // A request is never launched in a cycle whose address is about to be abandoned.
  assign issue = !rst && (state_q == ST_REQ) && (!buf_valid || instr_ready)
                 && !halt && !redir_any;

  assign imem.imem_req  = issue;
  assign imem.imem_addr = pc_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    halted_d  = halted_q;
    buf_load  = 1'b0;
    buf_flush = 1'b0;
    if (state_q != ST_HALTED) begin
      if (halt) begin
        state_d   = ST_HALTED;
        halted_d  = 1'b1;
        buf_flush = 1'b1;
      end else if (redir_any) begin
        pc_d      = {redir_tgt[ADDR_W-1:1], 1'b0};
        buf_flush = 1'b1;
        // A response still in flight must be discarded before the new target is fetched.
        if ((state_q == ST_WAIT || state_q == ST_DRAIN) && !imem.imem_valid)
          state_d = ST_DRAIN;
        else
          state_d = ST_REQ;
      end else begin
        case (state_q)
          ST_REQ: begin
            if (issue && imem.imem_rdy) begin
              pc_d    = pc_q + ADDR_W'(2);
              state_d = ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (imem.imem_valid) begin
              buf_load = 1'b1;
              state_d  = (opcode_of(imem.imem_data) == OP_HALT) ? ST_STOP : ST_REQ;
            end
          end
          ST_DRAIN: begin
            if (imem.imem_valid) state_d = ST_REQ;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_REQ;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
    end
  end

  fetch_out_reg #(
    .ADDR_W (ADDR_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_data (imem.imem_data),
    .load_pc2  (pc_q),
    .pop       (instr_ready),
    .flush     (buf_flush),
    .valid     (buf_valid),
    .data      (buf_data),
    .pc2       (buf_pc2)
  );

  assign instr       = buf_data;
  assign instr_pc2   = buf_pc2;
  assign instr_valid = buf_valid;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected fetch addresses and decoded words are queued by the
// stimulus; independent monitors pop and compare as the DUT presents requests and instructions.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr;
  logic [15:0] instr_pc2;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halt = 1'b0;
  logic        siic = 1'b0;
  logic        rti = 1'b0;
  logic        halted;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(16)) imem_bus ();

  fetch_unit #(
    .ADDR_W     (16),
    .RESET_PC   (16'h0000),
    .EXC_VECTOR (16'h0002)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .instr       (instr),
    .instr_pc2   (instr_pc2),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .siic        (siic),
    .rti         (rti),
    .halted      (halted)
  );

  typedef struct { logic [15:0] data; logic [15:0] pc2; } exp_instr_t;
  typedef struct { int due; logic [15:0] addr; } resp_t;

  exp_instr_t  exp_instr_q[$];
  logic [15:0] exp_addr_q[$];
  resp_t       resp_q[$];
  logic [15:0] mem [int];
  int          lat = 1;
  int          cyc = 0;
  int          req_cycles = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] actual);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %h, expected no such event", name, actual);
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return NOP_WORD;
  endfunction

  task automatic push_instr(input logic [15:0] data, input logic [15:0] pc2);
    exp_instr_t e;
    e.data = data;
    e.pc2  = pc2;
    exp_instr_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, check the reset state, release; returns at the start of the first live cycle.
  task automatic do_reset();
    rst = 1'b1;
    halt = 1'b0;
    redirect = 1'b0;
    siic = 1'b0;
    rti = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_imem_req", imem_bus.imem_req, 1'b0);
    check("rst_instr_valid", instr_valid, 1'b0);
    check("rst_instr", instr, NOP_WORD);
    check("rst_instr_pc2", instr_pc2, 16'h0000);
    check("rst_halted", halted, 1'b0);
    check("rst_imem_addr", imem_bus.imem_addr, 16'h0000);
    step();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((exp_instr_q.size() != 0 || exp_addr_q.size() != 0) && n < max_cycles) begin
      step();
      n++;
    end
    if (exp_instr_q.size() != 0 || exp_addr_q.size() != 0) begin
      fail_event("drain_timeout", exp_instr_q.size() + exp_addr_q.size());
      exp_instr_q.delete();
      exp_addr_q.delete();
    end
  endtask

  task automatic wait_valid(input int max_cycles);
    int n = 0;
    while (!instr_valid && n < max_cycles) begin
      step();
      n++;
    end
    if (!instr_valid) fail_event("valid_timeout", n);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Instruction memory: accepts every request, answers `lat` cycles later.
  initial begin
    imem_bus.imem_rdy   = 1'b1;
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_data  = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) resp_q.delete();
      else if (imem_bus.imem_req && imem_bus.imem_rdy)
        resp_q.push_back('{due: cyc + lat, addr: imem_bus.imem_addr});
      @(posedge clk);
      #1;
      if (resp_q.size() > 0 && resp_q[0].due == cyc) begin
        imem_bus.imem_valid = 1'b1;
        imem_bus.imem_data  = mem_rd(resp_q[0].addr);
        void'(resp_q.pop_front());
      end else begin
        imem_bus.imem_valid = 1'b0;
        imem_bus.imem_data  = 16'h0000;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (imem_bus.imem_req) req_cycles++;
  end

  initial begin : mon_addr
    logic [15:0] a;
    forever begin
      @(negedge clk);
      if (!rst && imem_bus.imem_req && imem_bus.imem_rdy) begin
        if (exp_addr_q.size() == 0) fail_event("imem_addr_unexpected", imem_bus.imem_addr);
        else begin
          a = exp_addr_q.pop_front();
          check("imem_addr", imem_bus.imem_addr, a);
        end
      end
    end
  end

  initial begin : mon_instr
    exp_instr_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && instr_ready) begin
        if (exp_instr_q.size() == 0) fail_event("instr_unexpected", instr);
        else begin
          e = exp_instr_q.pop_front();
          check("instr", instr, e.data);
          check("instr_pc2", instr_pc2, e.pc2);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // In-order stream, then a buffered HALT stops fetch and a halt pulse parks the unit.
    mem[32'h0] = 16'h4000;
    mem[32'h2] = 16'h4800;
    mem[32'h4] = 16'h0000;
    instr_ready = 1'b1;
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0002);
    exp_addr_q.push_back(16'h0004);
    push_instr(16'h4000, 16'h0002);
    push_instr(16'h4800, 16'h0004);
    push_instr(16'h0000, 16'h0006);
    do_reset();
    wait_drain(40);
    req_cycles = 0;
    repeat (4) step();
    check("stop_no_req", req_cycles, 0);
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_halted", halted, 1'b1);
    check("halt_instr_valid", instr_valid, 1'b0);
    check("halt_imem_req", imem_bus.imem_req, 1'b0);
    redirect = 1'b1;
    redirect_pc = 16'h0020;
    req_cycles = 0;
    step();
    redirect = 1'b0;
    repeat (3) step();
    check("halted_no_req", req_cycles, 0);
    check("halted_hold", halted, 1'b1);
    check("halted_pc", imem_bus.imem_addr, 16'h0006);

    // Stalled decode holds one word; then halt and redirect together.
    instr_ready = 1'b0;
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0002);
    exp_addr_q.push_back(16'h0004);
    push_instr(16'h4000, 16'h0002);
    push_instr(16'h4800, 16'h0004);
    push_instr(16'h0000, 16'h0006);
    do_reset();
    wait_valid(10);
    req_cycles = 0;
    repeat (5) step();
    check("hold_no_req", req_cycles, 0);
    check("hold_valid", instr_valid, 1'b1);
    check("hold_instr", instr, 16'h4000);
    check("hold_pc2", instr_pc2, 16'h0002);
    instr_ready = 1'b1;
    wait_drain(40);
    halt = 1'b1;
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    step();
    halt = 1'b0;
    redirect = 1'b0;
    check("halt_redir_halted", halted, 1'b1);
    req_cycles = 0;
    repeat (3) step();
    check("halt_redir_no_req", req_cycles, 0);
    check("halt_redir_pc", imem_bus.imem_addr, 16'h0006);

    // Redirect (odd target) while waiting on a 2-cycle response: stale word drained.
    mem[32'h40] = 16'h4800;
    mem[32'h42] = 16'h0000;
    mem[32'h80] = 16'h4000;
    mem[32'h90] = 16'h0000;
    lat = 2;
    exp_addr_q.push_back(16'h0000);
    exp_addr_q.push_back(16'h0040);
    exp_addr_q.push_back(16'h0042);
    push_instr(16'h4800, 16'h0042);
    push_instr(16'h0000, 16'h0044);
    do_reset();
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0041;
    step();
    redirect = 1'b0;
    wait_drain(40);

    // Redirect landing on the same cycle as the response: word dropped, no drain.
    lat = 1;
    exp_addr_q.push_back(16'h0080);
    exp_addr_q.push_back(16'h0090);
    push_instr(16'h0000, 16'h0092);
    redirect = 1'b1;
    redirect_pc = 16'h0080;
    step();
    redirect = 1'b0;
    step();
    redirect = 1'b1;
    redirect_pc = 16'h0090;
    step();
    redirect = 1'b0;
    wait_drain(40);

`ifdef FETCH_EXC_EN
    // SIIC at 0x0010 vectors to 0x0002; RTI returns to 0x0012.
    mem[32'h0]  = 16'h0000;
    mem[32'h2]  = 16'h0000;
    mem[32'h10] = 16'h1000;
    mem[32'h12] = 16'h0000;
    exp_addr_q.push_back(16'h0000);
    push_instr(16'h0000, 16'h0002);
    do_reset();
    wait_drain(40);
    instr_ready = 1'b0;
    exp_addr_q.push_back(16'h0010);
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    step();
    redirect = 1'b0;
    wait_valid(10);
    push_instr(16'h1000, 16'h0012);
    exp_addr_q.push_back(16'h0002);
    push_instr(16'h0000, 16'h0004);
    instr_ready = 1'b1;
    siic = 1'b1;
    step();
    siic = 1'b0;
    wait_drain(40);
    exp_addr_q.push_back(16'h0012);
    push_instr(16'h0000, 16'h0014);
    rti = 1'b1;
    step();
    rti = 1'b0;
    wait_drain(40);
`else
    // Without the exception feature siic/rti must not disturb a stopped fetch.
    req_cycles = 0;
    siic = 1'b1;
    rti = 1'b1;
    step();
    siic = 1'b0;
    rti = 1'b0;
    repeat (3) step();
    check("exc_ignored_no_req", req_cycles, 0);
    check("exc_ignored_pc", imem_bus.imem_addr, 16'h0092);
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
